// File: rtl/booth_operand_feeder_pkg.sv
// Shared widths, FSM encoding and bypass helpers for the Booth operand feeder.
package booth_operand_feeder_pkg;

  localparam int OPW   = 32;
  localparam int PRODW = 64;
  localparam int CNTW  = 5;

  // Multiplier value -1. The Booth core never runs its start/done sequence for it.
  localparam logic [OPW-1:0] MPLIER_MINUS_ONE = {OPW{1'b1}};

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_LAUNCH    = 3'd1,
    S_WAIT_BUSY = 3'd2,
    S_WAIT_DONE = 3'd3,
    S_BYPASS    = 3'd4,
    S_EMIT      = 3'd5
  } state_t;

  // The product is negated at full width, so an mcand of -2^31 gives +2^31 without overflow.
  function automatic logic [PRODW-1:0] negate_ext(input logic [OPW-1:0] v);
    return PRODW'(0) - {{(PRODW-OPW){v[OPW-1]}}, v};
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with a combinational head read and an occupancy count.
module sync_fifo #(
  parameter int WIDTH = 64,
  parameter int DEPTH = 4
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   push,
  input  logic [WIDTH-1:0]       din,
  input  logic                   pop,
  output logic [WIDTH-1:0]       dout,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] count
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign full    = (count == (AW+1)'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign dout    = mem[rd_ptr];

  always_ff @(posedge clock) begin
    if (do_push) mem[wr_ptr] <= din;
  end

  // DEPTH is a power of two, so the pointers wrap on their own.
  always_ff @(posedge clock) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/booth_operand_feeder.sv
// Queues operand pairs, runs them one at a time through the Booth multiplier and buffers results.
// Handshakes: a beat transfers on a rising edge where valid && ready; valid never waits on ready.
module booth_operand_feeder
  import booth_operand_feeder_pkg::*;
#(
  parameter int DEPTH   = 4,
  parameter int TIMEOUT = 48
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [OPW-1:0]         in_mcand,
  input  logic [OPW-1:0]         in_mplier,
  output logic [OPW-1:0]         mul_mcand,
  output logic [OPW-1:0]         mul_mplier,
  output logic                   mul_start,
  input  logic [PRODW-1:0]       mul_product,
  input  logic                   mul_done,
  input  logic [CNTW-1:0]        mul_add_count,
  input  logic [CNTW-1:0]        mul_sub_count,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [PRODW-1:0]       out_product,
  output logic [CNTW-1:0]        out_add_count,
  output logic [CNTW-1:0]        out_sub_count,
  output logic                   out_timeout,
  output logic [$clog2(DEPTH):0] fifo_count,
  output logic                   busy,
  output state_t                 state
);

  localparam int TW = $clog2(TIMEOUT + 1);

  state_t           next_state;
  logic             push;
  logic             pop;
  logic             fifo_full;
  logic             fifo_empty;
  logic [2*OPW-1:0] head;
  logic [OPW-1:0]   head_mcand;
  logic [OPW-1:0]   head_mplier;
  logic [TW-1:0]    wait_count;
  logic             timed_out;
  logic             out_free;
  logic             cap_mul;
  logic             cap_bypass;
  logic             cap_timeout;

  assign in_ready  = !fifo_full;
  assign push      = in_valid && in_ready;
  assign {head_mcand, head_mplier} = head;
  assign out_free  = !out_valid || out_ready;
  assign timed_out = (wait_count == TW'(TIMEOUT));
  assign busy      = (state != S_IDLE);

  sync_fifo #(
    .WIDTH(2*OPW),
    .DEPTH(DEPTH)
  ) u_fifo (
    .clock(clock),
    .reset(reset),
    .push (push),
    .din  ({in_mcand, in_mplier}),
    .pop  (pop),
    .dout (head),
    .full (fifo_full),
    .empty(fifo_empty),
    .count(fifo_count)
  );

  always_ff @(posedge clock) begin
    if (reset) state <= S_IDLE;
    else       state <= next_state;
  end

  always_comb begin
    next_state  = state;
    pop         = 1'b0;
    mul_start   = 1'b0;
    cap_mul     = 1'b0;
    cap_bypass  = 1'b0;
    cap_timeout = 1'b0;
    case (state)
      S_IDLE: begin
        if (!fifo_empty && out_free) begin
          pop = 1'b1;
          if (head_mplier == '0 || head_mplier == MPLIER_MINUS_ONE) next_state = S_BYPASS;
          else                                                      next_state = S_LAUNCH;
        end
      end
      S_LAUNCH: begin
        mul_start  = 1'b1;
        next_state = S_WAIT_BUSY;
      end
      // done is still high from the previous job until the core acknowledges the start.
      S_WAIT_BUSY: begin
        if (timed_out) begin
          cap_timeout = 1'b1;
          next_state  = S_EMIT;
        end else if (!mul_done) begin
          next_state = S_WAIT_DONE;
        end
      end
      S_WAIT_DONE: begin
        if (mul_done) begin
          cap_mul    = 1'b1;
          next_state = S_EMIT;
        end else if (timed_out) begin
          cap_timeout = 1'b1;
          next_state  = S_EMIT;
        end
      end
      S_BYPASS: begin
        cap_bypass = 1'b1;
        next_state = S_EMIT;
      end
      S_EMIT:  next_state = S_IDLE;
      default: next_state = S_IDLE;
    endcase
  end

  // Captures only happen while the buffer is empty: a pop requires it free, and the job's
  // own result is the only thing that can refill it.
  always_ff @(posedge clock) begin
    if (reset) begin
      mul_mcand     <= '0;
      mul_mplier    <= '0;
      wait_count    <= '0;
      out_valid     <= 1'b0;
      out_product   <= '0;
      out_add_count <= '0;
      out_sub_count <= '0;
      out_timeout   <= 1'b0;
    end else begin
      if (pop) begin
        mul_mcand  <= head_mcand;
        mul_mplier <= head_mplier;
      end

      if (state == S_LAUNCH)
        wait_count <= '0;
      else if (state == S_WAIT_BUSY || state == S_WAIT_DONE)
        wait_count <= wait_count + 1'b1;

      if (out_valid && out_ready) begin
        out_valid     <= 1'b0;
        out_product   <= '0;
        out_add_count <= '0;
        out_sub_count <= '0;
        out_timeout   <= 1'b0;
      end

      if (cap_mul) begin
        out_valid     <= 1'b1;
        out_product   <= mul_product;
        out_add_count <= mul_add_count;
        out_sub_count <= mul_sub_count;
        out_timeout   <= 1'b0;
      end else if (cap_timeout) begin
        out_valid     <= 1'b1;
        out_product   <= '0;
        out_add_count <= '0;
        out_sub_count <= '0;
        out_timeout   <= 1'b1;
      end else if (cap_bypass) begin
        out_valid     <= 1'b1;
        out_add_count <= '0;
        out_timeout   <= 1'b0;
        if (mul_mplier == '0) begin
          out_product   <= '0;
          out_sub_count <= '0;
        end else begin
          out_product   <= negate_ext(mul_mcand);
          out_sub_count <= CNTW'(1);
        end
      end
    end
  end

endmodule

// File: doc/booth_operand_feeder.md
Name: booth_operand_feeder

Overview:
- Sits directly upstream of the 32x32 Booth multiplier (`boothsalgo`).
- Queues signed operand pairs from a valid/ready source and launches one multiplication at a time using the multiplier's `signal_in`/`done_signal` protocol.
- Captures product and add/sub counts, and presents them on a valid/ready result port.
- Short-circuits multiplier values 0 and -1, which the multiplier does not run through its normal start/done sequence.

Parameters:
- DEPTH, 4, operand FIFO entries; power of two, range 2..16.
- TIMEOUT, 48, max cycles from start pulse to completion before aborting the job.

Ports:
- clock  in  1  single clock; all logic on posedge.
- reset  in  1  synchronous, active-high.
- in_valid  in  1  operand pair offered.
- in_ready  out  1  FIFO not full.
- in_mcand  in  32  signed multiplicand.
- in_mplier  in  32  signed multiplier.
- mul_mcand  out  32  to multiplier mcand.
- mul_mplier  out  32  to multiplier mplier.
- mul_start  out  1  to multiplier signal_in.
- mul_product  in  64  from multiplier product.
- mul_done  in  1  from multiplier done_signal.
- mul_add_count  in  5  from multiplier addOP.
- mul_sub_count  in  5  from multiplier subOP.
- out_valid  out  1  result held.
- out_ready  in  1  consumer accepts.
- out_product  out  64  signed product.
- out_add_count  out  5  Booth additions.
- out_sub_count  out  5  Booth subtractions.
- out_timeout  out  1  result aborted by timeout; product forced to 0.
- fifo_count  out  $clog2(DEPTH)+1  FIFO occupancy.
- busy  out  1  state != IDLE.

Behaviour:
- Reset values:
  - in_ready=1; mul_start=0; mul_mcand=0; mul_mplier=0.
  - out_valid=0; out_product=0; out_add_count=0; out_sub_count=0; out_timeout=0.
  - fifo_count=0; busy=0; state=IDLE; timeout counter=0.
- Reset mid-operation flushes the FIFO and any in-flight job. No result is emitted for it.
- FIFO:
  - Write when in_valid && in_ready.
  - Simultaneous push and pop when full is legal; in_ready reflects pre-pop fullness.
  - Pointers wrap modulo DEPTH.
- Output buffer:
  - One entry. out_* stay stable while out_valid && !out_ready.
  - Cleared on handshake.
- FSM states: IDLE, LAUNCH, WAIT_BUSY, WAIT_DONE, BYPASS, EMIT.
- IDLE:
  - If FIFO non-empty and output buffer empty (or emptying this cycle), pop the head into mul_mcand/mul_mplier.
  - Next state is BYPASS if the popped mplier is 0 or -1 (32'hFFFFFFFF); otherwise LAUNCH.
- LAUNCH: mul_start=1 for exactly this one cycle; operands stable. Next state is WAIT_BUSY; timeout counter cleared.
- WAIT_BUSY: wait for mul_done=0. This masks the stale done from the previous job. Then go to WAIT_DONE.
- WAIT_DONE: on mul_done=1, capture mul_product, mul_add_count and mul_sub_count into the output buffer. Then go to EMIT.
- Timeout:
  - Applies in WAIT_BUSY and WAIT_DONE. The counter increments each cycle.
  - When it reaches TIMEOUT: capture product=0, counts=0, out_timeout=1, then go to EMIT.
- BYPASS:
  - mplier 0: product=0, add=0, sub=0.
  - mplier -1: product = -sign_extend(mcand) (64-bit), add=0, sub=1.
  - mul_start is not asserted. Next state is EMIT.
  - -2^31 as mcand must give +2^31 in 64 bits (no overflow).
- EMIT: out_valid=1 from this cycle on; return to IDLE.
- Ordering:
  - Results leave strictly in input order.
  - Minimum input-to-out_valid latency when idle: 4 cycles for BYPASS (push, pop, compute, EMIT).
- Operands stay on mul_mcand/mul_mplier until the next pop, since the multiplier may sample them late.

Decomposition:
- Shared package holds:
  - state encoding localparams;
  - OPW=32, PRODW=64, CNTW=5;
  - the -1 constant used for bypass detection.
- One natural sub-module: `sync_fifo` (parameters WIDTH=64, DEPTH), with push/pop/full/empty/count. The feeder FSM stays in the top.

Test Plan:
- Push (113,4), with a multiplier model where done drops 1 cycle after start and returns 34 cycles later → out_product=452; counts passed through as add=1, sub=1; exactly one mul_start pulse.
- Push (20000,-1), then (0,0), then (-2147483648,-1) → products -20000, 0 and +2147483648 (sub=1, sub=0, sub=1); mul_start never asserts; results in order.
- Push 6 pairs back-to-back with DEPTH=4 → in_ready deasserts after 4 are queued (plus the one popped); all 6 products correct: -500*-10=5000 and 123456*123456=15241383936 included.
- Hold out_ready=0 for 100 cycles after first result → out_* stable, no second launch until the handshake; then drain in order.
- Multiplier model never raises done after start → out_timeout=1 and product=0 after TIMEOUT cycles; the next job (10,1) completes normally with product=10.
- Assert reset for 1 cycle during WAIT_DONE with 3 entries queued → next cycle: fifo_count=0, out_valid=0, busy=0, mul_start=0; no stale result is ever emitted.
